// File: rtl/nor_gate_n_filtered.sv
// N-input NOR with per-input bubbles, per-bit synchronisers, a deglitch filter on the
// reduced value, and registered single-cycle rise/fall pulses.
module nor_gate_n_filtered #(
  parameter int          NR_OF_INPUTS  = 4,
  parameter logic [63:0] BubblesMask   = 64'd1,
  parameter int          SYNC_STAGES   = 2,
  parameter int          FILTER_CYCLES = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NR_OF_INPUTS-1:0] inputs,
  output logic                    result,
  output logic                    result_rise,
  output logic                    result_fall,
  output logic                    filter_busy
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  // count value on which the next disagreeing tick commits the change
  localparam logic [CW-1:0] LAST_COUNT = CW'(FILTER_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_QUALIFY} state_t;

  logic [NR_OF_INPUTS-1:0] real_in;
  logic [NR_OF_INPUTS-1:0] sync;
  logic                    nor_now;

  assign real_in = inputs ^ BubblesMask[NR_OF_INPUTS-1:0];

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign sync = real_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][NR_OF_INPUTS-1:0] stage_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          stage_reg <= '0;
        end else if (tick) begin
          stage_reg[0] <= real_in;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            stage_reg[s] <= stage_reg[s-1];
          end
        end
      end

      assign sync = stage_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign nor_now = ~|sync;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic            result_reg;
  logic            rise_reg;
  logic            fall_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_STABLE;
      count_reg  <= '0;
      result_reg <= 1'b1;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      // pulses last one clock whether or not tick is present
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (tick) begin
        case (state_reg)
          ST_STABLE: begin
            if (nor_now != result_reg) begin
              if (FILTER_CYCLES == 1) begin
                result_reg <= nor_now;
                rise_reg   <= nor_now;
                fall_reg   <= ~nor_now;
              end else begin
                count_reg <= CW'(1);
                state_reg <= ST_QUALIFY;
              end
            end
          end
          ST_QUALIFY: begin
            if (nor_now == result_reg) begin
              count_reg <= '0;
              state_reg <= ST_STABLE;
            end else if (count_reg == LAST_COUNT) begin
              result_reg <= nor_now;
              rise_reg   <= nor_now;
              fall_reg   <= ~nor_now;
              count_reg  <= '0;
              state_reg  <= ST_STABLE;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
          default: begin
            count_reg <= '0;
            state_reg <= ST_STABLE;
          end
        endcase
      end
    end
  end

  assign result      = result_reg;
  assign result_rise = rise_reg;
  assign result_fall = fall_reg;
  assign filter_busy = (count_reg != '0);

endmodule

// File: tb/tb_nor_gate_n_filtered.sv
// Scoreboard bench: expected {result, rise, fall, busy} traces are queued when stimulus
// is applied and popped one per clock, sampled on the falling edge.
module tb_nor_gate_n_filtered;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick_ab;
  logic        tick_c;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [63:0] in_c;
  logic        res_a, rise_a, fall_a, busy_a;
  logic        res_b, rise_b, fall_b, busy_b;
  logic        res_c, rise_c, fall_c, busy_c;

  always #5 clock = ~clock;

  // plain NOR, default sync depth and filter length
  nor_gate_n_filtered #(.NR_OF_INPUTS(4), .BubblesMask(64'h0)) dut_a (
    .clock(clock), .reset(reset), .tick(tick_ab), .inputs(in_a),
    .result(res_a), .result_rise(rise_a), .result_fall(fall_a), .filter_busy(busy_a)
  );

  // bubbles on inputs 0 and 1
  nor_gate_n_filtered #(.NR_OF_INPUTS(4), .BubblesMask(64'h3)) dut_b (
    .clock(clock), .reset(reset), .tick(tick_ab), .inputs(in_b),
    .result(res_b), .result_rise(rise_b), .result_fall(fall_b), .filter_busy(busy_b)
  );

  // wide, unsynchronised, unfiltered, sparse ticks
  nor_gate_n_filtered #(.NR_OF_INPUTS(64), .BubblesMask(64'h0), .SYNC_STAGES(0),
                        .FILTER_CYCLES(1)) dut_c (
    .clock(clock), .reset(reset), .tick(tick_c), .inputs(in_c),
    .result(res_c), .result_rise(rise_c), .result_fall(fall_c), .filter_busy(busy_c)
  );

  typedef struct {
    int         dut;
    logic [3:0] exp;
    string      tag;
  } item_t;

  item_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check_vec(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {res,rise,fall,busy}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs(input int dut);
    case (dut)
      0:       return {res_a, rise_a, fall_a, busy_a};
      1:       return {res_b, rise_b, fall_b, busy_b};
      default: return {res_c, rise_c, fall_c, busy_c};
    endcase
  endfunction

  task automatic push(input int dut, input logic [3:0] e, input string tag);
    item_t it;
    it.dut = dut;
    it.exp = e;
    it.tag = tag;
    sb_q.push_back(it);
  endtask

  task automatic step();
    item_t it;
    @(posedge clock);
    @(negedge clock);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: no expected entry at %0t", $time);
    end else begin
      it = sb_q.pop_front();
      check_vec(it.tag, obs(it.dut), it.exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // sync 2 + filter 3: busy after edges 3-4, result changes with its pulse at edge 5
  task automatic fall_trace(input int dut, input string tag);
    push(dut, 4'b1000, tag); push(dut, 4'b1000, tag); push(dut, 4'b1001, tag);
    push(dut, 4'b1001, tag); push(dut, 4'b0010, tag); push(dut, 4'b0000, tag);
    push(dut, 4'b0000, tag);
  endtask

  task automatic rise_trace(input int dut, input string tag);
    push(dut, 4'b0000, tag); push(dut, 4'b0000, tag); push(dut, 4'b0001, tag);
    push(dut, 4'b0001, tag); push(dut, 4'b1100, tag); push(dut, 4'b1000, tag);
    push(dut, 4'b1000, tag);
  endtask

  initial begin
    logic [3:0] exp_c [12];
    exp_c = '{4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0000,
              4'b0000, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000};

    reset   = 1'b1;
    tick_ab = 1'b1;
    tick_c  = 1'b0;
    in_a    = 4'b0000;
    in_b    = 4'b0011;
    in_c    = '0;
    repeat (2) @(negedge clock);
    check_vec("reset_a", obs(0), 4'b1000);
    reset = 1'b0;

    // idle inputs keep result high and quiet
    for (int i = 0; i < 4; i++) push(0, 4'b1000, "a_idle");
    run(4);

    in_a = 4'b0100;
    fall_trace(0, "a_fall");
    run(7);
    in_a = 4'b0000;
    rise_trace(0, "a_rise");
    run(7);

    // two-clock glitch on input 1 is rejected
    in_a = 4'b0010;
    push(0, 4'b1000, "a_glitch"); push(0, 4'b1000, "a_glitch");
    run(2);
    in_a = 4'b0000;
    push(0, 4'b1001, "a_glitch"); push(0, 4'b1001, "a_glitch");
    push(0, 4'b1000, "a_glitch"); push(0, 4'b1000, "a_glitch");
    run(4);

    // bubbled inputs: 0011 reads as all-deasserted, dropping input 0 asserts it
    in_b = 4'b0010;
    fall_trace(1, "b_fall");
    run(7);
    in_b = 4'b0011;
    rise_trace(1, "b_rise");
    run(7);

    // tick on every 4th clock, change takes effect on the tick edge only
    in_c[63] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick_c = (k % 4 == 0);
      push(2, exp_c[k-1], "c_sparse");
      step();
      if (k == 6) in_c[63] = 1'b0;
    end
    tick_c = 1'b0;

    // reset while a fall is pending at count 2
    in_a = 4'b0100;
    push(0, 4'b1000, "a_prerst"); push(0, 4'b1000, "a_prerst");
    push(0, 4'b1001, "a_prerst"); push(0, 4'b1001, "a_prerst");
    run(4);
    reset = 1'b1;
    #1;
    check_vec("rst_async", obs(0), 4'b1000);
    in_a = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) push(0, 4'b1000, "a_postrst");
    run(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
